pipe_shift_reg: RTL

//  Parametrised pipeline register chain: WIDTH-bit data plus a valid bit through DEPTH stages.

---
 rtl/pipe_shift_reg.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pipe_shift_reg.sv
// ---------------------------------------------------------------------------
// pipe_shift_reg
//   Parametrised pipeline register chain. Each of DEPTH stages holds WIDTH
//   data bits plus a valid bit. The chain supports a global stall, a per-stage
//   kill (flush), and bubble insertion. Bubbles come from in_valid=0 or from
//   a kill.
//
// Parameters
//   WIDTH      data bits per stage
//   DEPTH      number of register stages
//   RST_VAL    data value loaded into every stage on reset
//   BUBBLE_VAL data value held by a stage that became invalid
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   stall      1 = every stage holds this cycle
//   kill       kill[i]=1 invalidates what stage i holds after this edge
//   in_valid   d carries a real entry
//   d          data into stage 0
//   q          data of the last stage
//   q_valid    valid bit of the last stage
//   valid_cnt  registered count of valid stages
// ---------------------------------------------------------------------------
module pipe_shift_reg #(
    parameter int              WIDTH      = 32,
    parameter int              DEPTH      = 1,
    parameter logic [WIDTH-1:0] RST_VAL    = '0,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
    localparam int             CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [DEPTH-1:0] kill,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [CNT_W-1:0] valid_cnt
);

    // Current contents of each stage, plus the valid bits each stage takes on
    // the coming edge. valid_cnt counts the latter.
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] stage_valid;
    logic [DEPTH-1:0] stage_valid_next;

    // With in_valid=0, a bubble is muxed in so an undefined d never gets stored.
    logic [WIDTH-1:0] in_data;
    assign in_data = in_valid ? d : BUBBLE_VAL;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] src_data;
            logic             src_valid;
            logic [WIDTH-1:0] data_q;
            logic [WIDTH-1:0] data_d;
            logic             valid_q;
            logic             valid_d;

            if (gi == 0) begin : g_head
                assign src_data  = in_data;
                assign src_valid = in_valid;
            end else begin : g_body
                assign src_data  = stage_data[gi-1];
                assign src_valid = stage_valid[gi-1];
            end

            // A kill beats a stall. When the chain moves, the killed stage
            // drops its incoming entry. Its old entry has already moved on to
            // stage gi+1 through that stage's src path.
            always_comb begin
                data_d  = data_q;
                valid_d = valid_q;
                if (kill[gi]) begin
                    data_d  = BUBBLE_VAL;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    data_d  = src_data;
                    valid_d = src_valid;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q  <= RST_VAL;
                    valid_q <= 1'b0;
                end else begin
                    data_q  <= data_d;
                    valid_q <= valid_d;
                end
            end

            assign stage_data[gi]       = data_q;
            assign stage_valid[gi]      = valid_q;
            assign stage_valid_next[gi] = valid_d;
        end
    endgenerate

    // The count is registered on the same edge as the stages. It is the
    // popcount of the valid bits being loaded, so it always matches them.
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + CNT_W'(stage_valid_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q         = stage_data[DEPTH-1];
    assign q_valid   = stage_valid[DEPTH-1];
    assign valid_cnt = cnt_q;

endmodule
